// File: rtl/adder_pkg.sv
// Shared types and the saturating-add helper for the adder result consumer.
package adder_pkg;

    localparam int unsigned DATA_W = 7;
    localparam int unsigned MAX_W  = 32;

    typedef enum logic {EMPTY, FULL} res_state_t;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Adds at MAX_W+1 bits and clamps to a w-bit all-ones ceiling.
    function automatic sat_res_t sat_add(input logic [MAX_W-1:0] acc,
                                         input logic [MAX_W-1:0] c,
                                         input int unsigned      w);
        logic [MAX_W:0] full;
        logic [MAX_W:0] ones;
        logic [MAX_W:0] lim;
        sat_res_t       r;
        full = {1'b0, acc} + {1'b0, c};
        ones = '1;
        lim  = ~(ones << w);
        if (full > lim) begin
            r.sum = lim[MAX_W-1:0];
            r.ovf = 1'b1;
        end else begin
            r.sum = full[MAX_W-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational ACC_W-bit saturating adder; ovf flags a clamped result.
module sat_adder
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W = adder_pkg::DATA_W,
    parameter int unsigned ACC_W  = 10
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] c,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    sat_res_t res;
    logic     unused_hi;

    always_comb begin
        res = sat_add(MAX_W'(acc), MAX_W'(c), ACC_W);
    end

    assign sum       = res.sum[ACC_W-1:0];
    assign ovf       = res.ovf;
    assign unused_hi = ^res.sum[MAX_W-1:ACC_W];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder results per batch and offers each total on a
// valid/ready port; batches that find the result register busy are dropped.
module sum_accumulator
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W = adder_pkg::DATA_W,
    parameter int unsigned COUNT  = 4,
    parameter int unsigned ACC_W  = 10,
    localparam int unsigned FILL_W = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] c,
    input  logic              valid,
    input  logic              clr,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              sat,
    output logic              overrun,
    output logic [FILL_W-1:0] fill
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              bsat_q, bsat_d;
    logic              ovr_q, ovr_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              sat_q, sat_d;
    res_state_t        state_q, state_d;

    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic              last;
    logic              done;

    sat_adder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .acc (acc_q),
        .c   (c),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign last = valid && (fill_q == FILL_W'(COUNT - 1));
    // clr discards a coincident sample, so it can never complete a batch.
    assign done = last && !clr;

    always_comb begin
        acc_d   = acc_q;
        fill_d  = fill_q;
        bsat_d  = bsat_q;
        ovr_d   = ovr_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        state_d = state_q;

        if (clr || last) begin
            acc_d  = '0;
            fill_d = '0;
            bsat_d = 1'b0;
        end else if (valid) begin
            acc_d  = add_sum;
            fill_d = fill_q + FILL_W'(1);
            bsat_d = bsat_q | add_ovf;
        end
        if (clr) begin
            ovr_d = 1'b0;
        end

        unique case (state_q)
            EMPTY: begin
                if (done) begin
                    sum_d   = add_sum;
                    sat_d   = bsat_q | add_ovf;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (done && sum_ready) begin
                    sum_d = add_sum;
                    sat_d = bsat_q | add_ovf;
                end else if (done) begin
                    ovr_d = 1'b1;
                end else if (sum_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            fill_q  <= '0;
            bsat_q  <= 1'b0;
            ovr_q   <= 1'b0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            bsat_q  <= bsat_d;
            ovr_q   <= ovr_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            state_q <= state_d;
        end
    end

    assign sum       = sum_q;
    assign sat       = sat_q;
    assign sum_valid = (state_q == FULL);
    assign overrun   = ovr_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 10-bit and an 8-bit accumulator share stimulus.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] c;
    logic       valid;
    logic       clr;
    logic       sum_ready;

    logic [9:0] sum;
    logic       sum_valid, sat, overrun;
    logic [1:0] fill;
    logic [7:0] sum8;
    logic       sum_valid8, sat8, overrun8;
    logic [1:0] fill8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.DATA_W(7), .COUNT(4), .ACC_W(10)) dut (
        .clk (clk), .rst (rst), .c (c), .valid (valid), .clr (clr),
        .sum (sum), .sum_valid (sum_valid), .sum_ready (sum_ready),
        .sat (sat), .overrun (overrun), .fill (fill)
    );

    sum_accumulator #(.DATA_W(7), .COUNT(4), .ACC_W(8)) dut8 (
        .clk (clk), .rst (rst), .c (c), .valid (valid), .clr (clr),
        .sum (sum8), .sum_valid (sum_valid8), .sum_ready (sum_ready),
        .sat (sat8), .overrun (overrun8), .fill (fill8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge pass, settle 1 time unit after it.
    task automatic step(input logic [6:0] cv, input logic v);
        c     = cv;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; c = '0; valid = 1'b0; clr = 1'b0; sum_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 32'(sum), 0);
        chk("rst_sum_valid", 32'(sum_valid), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_fill", 32'(fill), 0);
        rst = 1'b0;

        // Back-to-back batch 10,20,30,40
        step(10, 1); chk("b2b_fill1", 32'(fill), 1);
        step(20, 1); chk("b2b_fill2", 32'(fill), 2);
        step(30, 1); chk("b2b_fill3", 32'(fill), 3);
        chk("b2b_not_yet", 32'(sum_valid), 0);
        step(40, 1);
        chk("b2b_valid", 32'(sum_valid), 1);
        chk("b2b_sum", 32'(sum), 100);
        chk("b2b_sat", 32'(sat), 0);
        chk("b2b_fill0", 32'(fill), 0);
        chk("b2b_sum8", 32'(sum8), 100);
        step(0, 0);
        chk("b2b_valid_drop", 32'(sum_valid), 0);

        // Same values with idle gaps
        step(10, 1); chk("gap_fill1", 32'(fill), 1);
        step(0, 0);  chk("gap_hold1", 32'(fill), 1);
        step(20, 1); chk("gap_fill2", 32'(fill), 2);
        step(0, 0); step(0, 0);
        chk("gap_hold2", 32'(fill), 2);
        step(30, 1); chk("gap_fill3", 32'(fill), 3);
        step(0, 0); step(0, 0); step(0, 0);
        chk("gap_hold3", 32'(fill), 3);
        chk("gap_no_valid", 32'(sum_valid), 0);
        step(40, 1);
        chk("gap_sum", 32'(sum), 100);
        chk("gap_valid", 32'(sum_valid), 1);
        chk("gap_fill0", 32'(fill), 0);
        step(0, 0);

        // Backpressure: batch B dropped while A is held
        sum_ready = 1'b0;
        step(1, 1); step(2, 1); step(3, 1); step(4, 1);
        chk("bp_a_sum", 32'(sum), 10);
        chk("bp_a_valid", 32'(sum_valid), 1);
        step(5, 1); step(5, 1); step(5, 1);
        chk("bp_no_ovr_yet", 32'(overrun), 0);
        step(5, 1);
        chk("bp_ovr", 32'(overrun), 1);
        chk("bp_sum_held", 32'(sum), 10);
        chk("bp_valid_held", 32'(sum_valid), 1);
        step(0, 0);
        chk("bp_sum_stable", 32'(sum), 10);
        sum_ready = 1'b1;
        step(0, 0);
        chk("bp_accept", 32'(sum_valid), 0);
        chk("bp_ovr_sticky", 32'(overrun), 1);

        // clr clears the overrun flag; then handshake coincident with completion
        sum_ready = 1'b0;
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
        chk("clr_ovr", 32'(overrun), 0);
        step(1, 1); step(2, 1); step(3, 1); step(4, 1);
        chk("hs_a_sum", 32'(sum), 10);
        step(5, 1); step(5, 1); step(5, 1);
        sum_ready = 1'b1;
        step(5, 1);
        chk("hs_b_sum", 32'(sum), 20);
        chk("hs_b_valid", 32'(sum_valid), 1);
        chk("hs_no_ovr", 32'(overrun), 0);
        step(0, 0);
        chk("hs_drop", 32'(sum_valid), 0);

        // Saturation on the 8-bit instance, then an unsaturated batch
        step(127, 1); step(127, 1); step(127, 1); step(127, 1);
        chk("sat8_sum", 32'(sum8), 255);
        chk("sat8_sat", 32'(sat8), 1);
        chk("sat10_sum", 32'(sum), 508);
        chk("sat10_sat", 32'(sat), 0);
        step(1, 1); step(1, 1); step(1, 1); step(1, 1);
        chk("unsat8_sum", 32'(sum8), 4);
        chk("unsat8_sat", 32'(sat8), 0);
        step(0, 0);

        // clr with valid discards the sample and partial batch
        step(1, 1); step(2, 1);
        chk("clr_pre_fill", 32'(fill), 2);
        clr = 1'b1;
        step(9, 1);
        clr = 1'b0;
        chk("clr_fill", 32'(fill), 0);
        chk("clr_no_valid", 32'(sum_valid), 0);
        step(4, 1); step(4, 1); step(4, 1); step(4, 1);
        chk("clr_sum", 32'(sum), 16);
        chk("clr_valid", 32'(sum_valid), 1);
        step(0, 0);

        // Reset mid-batch with a pending result
        sum_ready = 1'b0;
        step(1, 1); step(1, 1); step(1, 1); step(1, 1);
        chk("pend_sum", 32'(sum), 4);
        step(3, 1); step(3, 1);
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_valid", 32'(sum_valid), 0);
        chk("mid_rst_fill", 32'(fill), 0);
        chk("mid_rst_sat", 32'(sat), 0);
        chk("mid_rst_ovr", 32'(overrun), 0);
        sum_ready = 1'b1;
        step(5, 1); step(6, 1); step(7, 1);
        chk("post_rst_fill", 32'(fill), 3);
        step(8, 1);
        chk("post_rst_sum", 32'(sum), 26);
        chk("post_rst_valid", 32'(sum_valid), 1);
        step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
